// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: hazard/branch controls and the instruction-memory port in,
// plus the IF/ID register and status out.
interface instruction_fetch_unit_if #(
  parameter int n = 32
);
  logic         freeze;
  logic         branch_taken;
  logic [n-1:0] branch_addr;
  logic [n-1:0] instruction;
  logic [n-1:0] PC;
  logic [n-1:0] if_id_pc;
  logic [n-1:0] if_id_instruction;
  logic         if_id_valid;
  logic         halted;
  logic [31:0]  fetch_count;

  modport master (
    input  freeze, branch_taken, branch_addr, instruction,
    output PC, if_id_pc, if_id_instruction, if_id_valid, halted, fetch_count
  );

  modport slave (
    output freeze, branch_taken, branch_addr, instruction,
    input  PC, if_id_pc, if_id_instruction, if_id_valid, halted, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage with IF/ID register, freeze, branch redirect and
// self-loop halt detection.
module instruction_fetch_unit #(
  parameter int           n         = 32,
  parameter logic [n-1:0] RESET_PC  = '0,
  parameter logic [n-1:0] HALT_WORD = 32'hA800FFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t       state_r, state_s;
  logic [n-1:0] pc_r, pc_s;
  logic [n-1:0] if_id_pc_r, if_id_pc_s;
  logic [n-1:0] if_id_instr_r, if_id_instr_s;
  logic         if_id_valid_r, if_id_valid_s;
  logic         halted_r, halted_s;
  logic [31:0]  fetch_count_r, fetch_count_s;
  logic [n-1:0] pc_plus4_s;

  assign pc_plus4_s = pc_r + n'(32'd4);

  // Next-state and next-register selection; the first matching rule wins.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    if_id_pc_s    = if_id_pc_r;
    if_id_instr_s = if_id_instr_r;
    if_id_valid_s = if_id_valid_r;
    fetch_count_s = fetch_count_r;
    if (bus.branch_taken) begin
      // A redirect outranks freeze and halt: anything fetched so far was wrong-path.
      pc_s          = bus.branch_addr;
      if_id_pc_s    = {n{1'b0}};
      if_id_instr_s = {n{1'b0}};
      if_id_valid_s = 1'b0;
      state_s       = ST_RUN;
    end else if (state_r == ST_HALTED) begin
      if_id_pc_s    = {n{1'b0}};
      if_id_instr_s = {n{1'b0}};
      if_id_valid_s = 1'b0;
    end else if (bus.freeze) begin
      pc_s = pc_r;
    end else if (bus.instruction == HALT_WORD) begin
      if_id_pc_s    = {n{1'b0}};
      if_id_instr_s = {n{1'b0}};
      if_id_valid_s = 1'b0;
      state_s       = ST_HALTED;
    end else begin
      if_id_instr_s = bus.instruction;
      if_id_pc_s    = pc_plus4_s;
      if_id_valid_s = 1'b1;
      pc_s          = pc_plus4_s;
      fetch_count_s = fetch_count_r + 32'd1;
    end
    halted_s = (state_s == ST_HALTED);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RUN;
      pc_r          <= RESET_PC;
      if_id_pc_r    <= {n{1'b0}};
      if_id_instr_r <= {n{1'b0}};
      if_id_valid_r <= 1'b0;
      halted_r      <= 1'b0;
      fetch_count_r <= 32'd0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      if_id_pc_r    <= if_id_pc_s;
      if_id_instr_r <= if_id_instr_s;
      if_id_valid_r <= if_id_valid_s;
      halted_r      <= halted_s;
      fetch_count_r <= fetch_count_s;
    end
  end

  assign bus.PC                = pc_r;
  assign bus.if_id_pc          = if_id_pc_r;
  assign bus.if_id_instruction = if_id_instr_r;
  assign bus.if_id_valid       = if_id_valid_r;
  assign bus.halted            = halted_r;
  assign bus.fetch_count       = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus a randomized
// run, checked against a rule-level reference model of the fetch stage.
module tb_instruction_fetch_unit;
  localparam logic [31:0] HALT = 32'hA800FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] mem [128];

  // reference model state
  logic [31:0]  m_pc, m_ifpc, m_inst, m_cnt;
  logic         m_valid, m_halt;
  logic [129:0] expv;
  logic [129:0] obs;

  instruction_fetch_unit_if #(.n(32)) ifc ();

  instruction_fetch_unit #(.n(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  always_comb ifc.instruction = mem[ifc.PC[8:2]];

  assign obs = {ifc.PC, ifc.if_id_pc, ifc.if_id_instruction, ifc.if_id_valid, ifc.halted, ifc.fetch_count};

  function automatic void pack_exp();
    expv = {m_pc, m_ifpc, m_inst, m_valid, m_halt, m_cnt};
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_ifpc = 32'd0; m_inst = 32'd0; m_valid = 1'b0; m_halt = 1'b0; m_cnt = 32'd0;
    pack_exp();
  endtask

  task automatic bubble();
    m_ifpc = 32'd0; m_inst = 32'd0; m_valid = 1'b0;
  endtask

  // One clock: drive controls, advance the model by the fetch rules, sample after the edge.
  task automatic drive_step(input logic f, input logic b, input logic [31:0] a);
    logic [31:0] w;
    ifc.freeze = f; ifc.branch_taken = b; ifc.branch_addr = a;
    w = mem[m_pc[8:2]];
    if (b) begin
      m_pc = a; bubble(); m_halt = 1'b0;
    end else if (m_halt) begin
      bubble();
    end else if (f) begin
      m_pc = m_pc;
    end else if (w == HALT) begin
      bubble(); m_halt = 1'b1;
    end else begin
      m_inst = w; m_ifpc = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end
    pack_exp();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic f);
    ifc.freeze = f; ifc.branch_taken = 1'b0; ifc.branch_addr = 32'd0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    total++;
    if (obs !== 130'd0) begin
      bad++; $display("FAIL reset got=%h want=%h", obs, 130'd0);
    end
  endtask

  task automatic test_straight();
    for (int i = 0; i < 3; i++) begin
      drive_step(1'b0, 1'b0, 32'd0);
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL straight[%0d] got=%h want=%h", i, obs, expv);
      end
    end
    total++;
    if ({ifc.PC, ifc.if_id_pc, ifc.if_id_instruction, ifc.fetch_count} !== {32'd12, 32'd12, 32'h04400800, 32'd3}) begin
      bad++; $display("FAIL straight_end got pc=%h ifpc=%h inst=%h cnt=%0d want 0c 0c 04400800 3",
                      ifc.PC, ifc.if_id_pc, ifc.if_id_instruction, ifc.fetch_count);
    end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 4; i++) begin
      drive_step(i < 3, 1'b0, 32'd0);
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL freeze[%0d] got=%h want=%h", i, obs, expv);
      end
    end
    total++;
    if ({ifc.PC, ifc.if_id_pc, ifc.fetch_count} !== {32'd16, 32'd16, 32'd4}) begin
      bad++; $display("FAIL freeze_end got pc=%h ifpc=%h cnt=%0d want 10 10 4", ifc.PC, ifc.if_id_pc, ifc.fetch_count);
    end
  endtask

  task automatic test_branch();
    drive_step(1'b1, 1'b1, 32'h100);
    total++;
    if ({ifc.PC, ifc.if_id_valid, ifc.if_id_instruction, ifc.fetch_count} !== {32'h100, 1'b0, 32'd0, 32'd4}) begin
      bad++; $display("FAIL branch_redirect got pc=%h v=%b inst=%h cnt=%0d", ifc.PC, ifc.if_id_valid, ifc.if_id_instruction, ifc.fetch_count);
    end
    drive_step(1'b0, 1'b0, 32'd0);
    total++;
    if ({ifc.if_id_pc, ifc.if_id_instruction, ifc.if_id_valid} !== {32'h104, mem[64], 1'b1}) begin
      bad++; $display("FAIL branch_target got ifpc=%h inst=%h want 104 %h", ifc.if_id_pc, ifc.if_id_instruction, mem[64]);
    end
  endtask

  task automatic test_halt();
    logic [31:0] cnt_at_halt;
    drive_step(1'b0, 1'b1, 32'h150);
    for (int i = 0; i < 5; i++) drive_step(1'b0, 1'b0, 32'd0);
    cnt_at_halt = m_cnt;
    for (int i = 0; i < 6; i++) begin
      drive_step(1'($urandom_range(0, 1)), 1'b0, 32'd0);
      total++;
      if ({ifc.PC, ifc.halted, ifc.if_id_valid, ifc.fetch_count} !== {32'h160, 1'b1, 1'b0, cnt_at_halt}) begin
        bad++; $display("FAIL halted[%0d] got pc=%h h=%b v=%b cnt=%0d want 160 1 0 %0d",
                        i, ifc.PC, ifc.halted, ifc.if_id_valid, ifc.fetch_count, cnt_at_halt);
      end
    end
    drive_step(1'b0, 1'b1, 32'h20);
    total++;
    if ({ifc.PC, ifc.halted} !== {32'h20, 1'b0}) begin
      bad++; $display("FAIL halt_exit got pc=%h h=%b want 20 0", ifc.PC, ifc.halted);
    end
    drive_step(1'b0, 1'b0, 32'd0);
    total++;
    if (obs !== expv) begin
      bad++; $display("FAIL halt_resume got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_random();
    logic f, b;
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 15) == 0);
      a = ($urandom_range(0, 7) == 0) ? 32'h15C : $urandom;
      drive_step(f, b, a);
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL random[%0d] got=%h want=%h", i, obs, expv);
      end
    end
  endtask

  task automatic test_wrap();
    drive_step(1'b0, 1'b1, 32'hFFFFFFFC);
    drive_step(1'b0, 1'b0, 32'd0);
    total++;
    if ({ifc.PC, ifc.if_id_pc, ifc.if_id_valid, ifc.if_id_instruction} !== {32'd0, 32'd0, 1'b1, mem[127]}) begin
      bad++; $display("FAIL wrap got pc=%h ifpc=%h v=%b inst=%h want 0 0 1 %h",
                      ifc.PC, ifc.if_id_pc, ifc.if_id_valid, ifc.if_id_instruction, mem[127]);
    end
  endtask

  task automatic test_reset_mid();
    drive_step(1'b0, 1'b1, 32'h160);
    drive_step(1'b0, 1'b0, 32'd0);
    total++;
    if (ifc.halted !== 1'b1) begin
      bad++; $display("FAIL pre_reset_halt got=%b want=1", ifc.halted);
    end
    do_reset(1'b1);
    total++;
    if (obs !== 130'd0) begin
      bad++; $display("FAIL reset_mid got=%h want=%h", obs, 130'd0);
    end
    drive_step(1'b0, 1'b0, 32'd0);
    total++;
    if ({ifc.PC, ifc.if_id_pc, ifc.if_id_instruction, ifc.fetch_count} !== {32'd4, 32'd4, 32'h8020000A, 32'd1}) begin
      bad++; $display("FAIL reset_restart got pc=%h ifpc=%h inst=%h cnt=%0d want 4 4 8020000a 1",
                      ifc.PC, ifc.if_id_pc, ifc.if_id_instruction, ifc.fetch_count);
    end
  endtask

  initial begin
    ifc.freeze = 1'b0; ifc.branch_taken = 1'b0; ifc.branch_addr = 32'd0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT) mem[i] = mem[i] ^ 32'd1;
    end
    mem[0]  = 32'h8020000A;
    mem[1]  = 32'h00000000;
    mem[2]  = 32'h04400800;
    mem[88] = HALT;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_straight();
    test_freeze();
    test_branch();
    test_halt();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage and IF/ID pipeline register for the 5-stage MIPS-style pipeline. It drives the byte address `PC` into the combinational-read instruction memory and captures the returned word into the IF/ID register. It resolves freezes from the hazard unit and taken branches from the execute stage. It stops the front end when the self-loop halt word (`JMP -1`) is fetched.

## Interface
- `n`, 32: datapath / address width.
- `RESET_PC`, 0: PC value after reset.
- `HALT_WORD`, 32'hA800FFFF: encoding of `JMP -1`, i.e. opcode 101010 with offset all ones.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high; one clock.
- `freeze`  in  1  hazard-unit stall; holds PC and IF/ID.
- `branch_taken`  in  1  execute stage redirect.
- `branch_addr`  in  n  redirect byte address.
- `instruction`  in  n  word returned by instruction memory for current `PC` (same cycle, combinational).
- `PC`  out  n  fetch byte address to instruction memory (memory indexes `PC[8:2]`).
- `if_id_pc`  out  n  PC+4 of captured instruction.
- `if_id_instruction`  out  n  captured instruction; bubble = 32'b0 (NOP).
- `if_id_valid`  out  1  captured instruction is real (not bubble).
- `halted`  out  1  halt word fetched; front end stopped.
- `fetch_count`  out  32  number of instructions delivered to IF/ID.

## Operation
- State machine: RUN, HALTED. Reset → RUN.
- Reset values:
  - `PC` = `RESET_PC`.
  - `if_id_pc` = 0, `if_id_instruction` = 0, `if_id_valid` = 0.
  - `halted` = 0, `fetch_count` = 0.
- Each non-reset edge applies the first matching rule:
  1. `branch_taken`:
     - `PC` ← `branch_addr`.
     - IF/ID ← bubble (pc 0, instr 0, valid 0).
     - State ← RUN.
     - Overrides `freeze` and HALTED; the halt word was wrong-path.
  2. State HALTED:
     - `PC` held.
     - IF/ID ← bubble.
  3. `freeze`:
     - `PC`, IF/ID and `fetch_count` held unchanged.
  4. `instruction == HALT_WORD`:
     - `PC` held.
     - IF/ID ← bubble.
     - State ← HALTED.
     - Not delivered downstream; `fetch_count` unchanged.
  5. Otherwise:
     - `if_id_instruction` ← `instruction`, `if_id_pc` ← `PC`+4, `if_id_valid` ← 1.
     - `PC` ← `PC`+4.
     - `fetch_count` += 1.
- `halted` = (state == HALTED), registered.
- Arithmetic:
  - `PC`+4 is modulo 2^n; wrap from 2^n−4 to 0 is silent.
  - `fetch_count` wraps modulo 2^32.
  - `branch_addr` is loaded verbatim. Low bits are not masked; memory ignores `PC[1:0]`.
- All-zero words (NOPs inserted in the program) are fetched, delivered with valid=1 and counted.
- `freeze` has no effect while HALTED.
- `rst` asserted mid-operation, including while HALTED or frozen, returns every output to its reset value on that edge.

## Timing
- `PC` is a register; `instruction` must settle combinationally within the same cycle.
- Fetch-to-IF/ID latency: 1 cycle. The word at `PC`=A appears on `if_id_instruction` after the next edge, with `if_id_pc`=A+4.
- Branch penalty:
  - One bubble in IF/ID on the redirect edge.
  - The target word is captured on the following edge.
  - Older wrong-path stages are flushed by the downstream stages, not by this block.
- Freeze is edge-exact: N cycles of `freeze`=1 hold outputs for exactly N edges, with no duplicate and no lost fetch.
- Halt: `halted` rises on the edge after the halt word is presented. `PC` remains equal to the halt word's address.

## Test plan
- Reset then straight-line fetch:
  - Stimulus: memory words at 0,4,8 = 32'h8020000A, 0, 32'h04400800.
  - Required: `PC` 0→4→8→12 on successive edges; `if_id_pc` 4,8,12 with the matching instructions.
  - Required: `if_id_valid`=1 from the first edge; `fetch_count` 1,2,3.
- Freeze:
  - Stimulus: `freeze`=1 for 3 cycles while `PC`=12.
  - Required: `PC`=12 and IF/ID unchanged for 3 edges; the next word is captured exactly once afterwards; `fetch_count` advances by 1 only after release.
- Branch:
  - Stimulus: `branch_taken`=1, `branch_addr`=0x100 together with `freeze`=1.
  - Required: `PC`=0x100, IF/ID bubble (valid 0, instr 0), `fetch_count` unchanged.
  - Required: the next edge captures the word at 0x100 with `if_id_pc`=0x104.
- Halt:
  - Stimulus: word 32'hA800FFFF at 0x160.
  - Required: `PC` stays 0x160, `halted`=1, bubbles forever, `fetch_count` frozen.
  - Then `branch_taken`, `branch_addr`=0x20 → `halted`=0, `PC`=0x20, fetching resumes.
- Wrap and reset:
  - Stimulus: with n=32, branch to 0xFFFFFFFC with a non-halt word there.
  - Required: `PC` wraps to 0, `if_id_pc`=0.
  - Stimulus: assert `rst` for one edge while HALTED and frozen.
  - Required: all outputs at reset values; fetch restarts at `RESET_PC`.
